// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and default frame shape.
// The defaults are shared with the receiver so that both ends agree on the frame format.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } uart_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam int DEFAULT_DATA_BITS = 8;
  localparam int DEFAULT_PARITY    = PARITY_NONE;
  localparam int DEFAULT_STOP_BITS = 1;

endpackage

// File: rtl/uart_tx_baud_edge_detect.sv
// Turns the divider's baud level into a one-cycle pulse on each rising edge.
// The level is treated as data in the system clock domain, never as a clock.
module baud_edge_detect (
  input  logic clock,
  input  logic reset_n,
  input  logic baud_clock,
  output logic tick
);

  logic baud_q;

  // delayed copy of the baud level for edge detection
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      baud_q <= 1'b0;
    end else begin
      baud_q <= baud_clock;
    end
  end

  assign tick = baud_clock & ~baud_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a word over valid/ready and sends start, data (LSB first),
// optional parity and stop bits, one bit per rising edge of the baud level.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter int PARITY    = DEFAULT_PARITY,
  parameter int STOP_BITS = DEFAULT_STOP_BITS
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 baud_clock,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int CW = $clog2(DATA_BITS + 1);

  uart_state_t          state_r;
  logic [DATA_BITS-1:0] shift_r;
  logic [CW-1:0]        count_r;
  logic                 parity_r;
  logic                 tick;

  function automatic logic calc_parity(input logic [DATA_BITS-1:0] data);
    if (PARITY == PARITY_ODD) begin
      calc_parity = ~^data;
    end else begin
      calc_parity = ^data;
    end
  endfunction

  baud_edge_detect u_edge (
    .clock      (clock),
    .reset_n    (reset_n),
    .baud_clock (baud_clock),
    .tick       (tick)
  );

  // frame sequencer; WAIT exists so that a tick coinciding with the accept cannot shorten the start bit
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      shift_r  <= '0;
      count_r  <= '0;
      parity_r <= 1'b0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          tx       <= 1'b1;
          tx_ready <= 1'b1;
          if (tx_valid) begin
            shift_r  <= tx_data;
            parity_r <= calc_parity(tx_data);
            count_r  <= '0;
            busy     <= 1'b1;
            tx_ready <= 1'b0;
            state_r  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (tick) begin
            tx      <= 1'b0;
            state_r <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            tx      <= shift_r[0];
            shift_r <= {1'b0, shift_r[DATA_BITS-1:1]};
            count_r <= CW'(1);
            state_r <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (count_r < CW'(DATA_BITS)) begin
              tx      <= shift_r[0];
              shift_r <= {1'b0, shift_r[DATA_BITS-1:1]};
              count_r <= count_r + CW'(1);
            end else if (PARITY != PARITY_NONE) begin
              tx      <= parity_r;
              state_r <= ST_PARITY;
            end else begin
              tx      <= 1'b1;
              count_r <= CW'(1);
              state_r <= ST_STOP;
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            tx      <= 1'b1;
            count_r <= CW'(1);
            state_r <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (count_r < CW'(STOP_BITS)) begin
              count_r <= count_r + CW'(1);
            end else begin
              busy     <= 1'b0;
              tx_ready <= 1'b1;
              tx_done  <= 1'b1;
              state_r  <= ST_IDLE;
            end
          end
        end
        default: begin
          tx       <= 1'b1;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
